shift_unit_arbiter: RTL and testbench

//  Shares one 32-bit shift datapath (SLL/SRL/SRA) between NUM_REQ requesters.

---
 rtl/shift_unit_pkg.sv | 17 +
 rtl/shift_unit_arbiter_rr_arbiter.sv | 45 ++++
 rtl/shift_unit_arbiter_shifters.sv | 36 +++
 rtl/shift_unit_arbiter.sv | 131 +++++++++++++
 tb/tb_shift_unit_arbiter.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/shift_unit_pkg.sv
// Shared op codes and FSM state encodings for the shared shift unit.
package shift_unit_pkg;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ILL = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    function automatic logic op_is_ill(input logic [1:0] op);
        return op == OP_ILL;
    endfunction

endpackage

// File: rtl/shift_unit_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant while enabled; priority rotates past each winner.
module rr_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic                       en_i,
    output logic [NUM_REQ-1:0]         grant_o,
    output logic [$clog2(NUM_REQ)-1:0] idx_o
);
    localparam int IW = $clog2(NUM_REQ);

    logic [IW-1:0] ptr_q;
    logic [IW-1:0] ptr_d;
    logic [IW-1:0] cand;
    logic          found;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        cand    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = IW'((int'(ptr_q) + k) % NUM_REQ);
            if (en_i && !found && req_i[cand]) begin
                found         = 1'b1;
                grant_o[cand] = 1'b1;
                idx_o         = cand;
            end
        end
    end

    // A grant is always a handshake (req high by construction), so rotate on it.
    assign ptr_d = (idx_o == IW'(NUM_REQ - 1)) ? '0 : idx_o + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (found) begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/shift_unit_arbiter_shifters.sv
// Shift primitives; any shift amount at or beyond WIDTH saturates to zero or sign fill.
module sll_32 #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] y_o
);
    localparam int SW = $clog2(WIDTH);
    assign y_o = (b_i >= WIDTH'(WIDTH)) ? '0 : (a_i << b_i[SW-1:0]);
endmodule

module srl_32 #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] y_o
);
    localparam int SW = $clog2(WIDTH);
    assign y_o = (b_i >= WIDTH'(WIDTH)) ? '0 : (a_i >> b_i[SW-1:0]);
endmodule

module sra_32 #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] y_o
);
    localparam int SW = $clog2(WIDTH);
    logic signed [WIDTH-1:0] a_s;
    assign a_s = a_i;
    assign y_o = (b_i >= WIDTH'(WIDTH)) ? {WIDTH{a_i[WIDTH-1]}}
                                        : $unsigned(a_s >>> b_i[SW-1:0]);
endmodule

// File: rtl/shift_unit_arbiter.sv
// One shared SLL/SRL/SRA datapath, round-robin shared between NUM_REQ requesters,
// one op in flight: IDLE -> EXEC -> HOLD until the owner accepts the result.
module shift_unit_arbiter
    import shift_unit_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int WIDTH   = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [2*NUM_REQ-1:0]     req_op,
    input  logic [WIDTH*NUM_REQ-1:0] req_a,
    input  logic [WIDTH*NUM_REQ-1:0] req_b,
    output logic [NUM_REQ-1:0]       rsp_valid,
    input  logic [NUM_REQ-1:0]       rsp_ready,
    output logic [WIDTH-1:0]         rsp_data,
    output logic                     rsp_err,
    output logic                     busy
);
    localparam int OW = $clog2(NUM_REQ);

    logic [1:0]         state_q, state_d;
    logic [OW-1:0]      owner_q, owner_d;
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0]   rsp_data_q, rsp_data_d;
    logic               rsp_err_q, rsp_err_d;
    logic [1:0]         op_q;
    logic [WIDTH-1:0]   a_q, b_q;

    logic               accept;
    logic               arb_en;
    logic [NUM_REQ-1:0] grant;
    logic [OW-1:0]      gnt_idx;
    logic               capture;
    logic [WIDTH-1:0]   sll_y, srl_y, sra_y, shift_res;

    assign accept  = (state_q == ST_HOLD) && rsp_ready[owner_q];
    assign arb_en  = (state_q == ST_IDLE) || accept;
    assign capture = |grant;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req_i   (req_valid),
        .en_i    (arb_en),
        .grant_o (grant),
        .idx_o   (gnt_idx)
    );

    assign req_ready = grant;

    sll_32 #(.WIDTH(WIDTH)) u_sll (.a_i(a_q), .b_i(b_q), .y_o(sll_y));
    srl_32 #(.WIDTH(WIDTH)) u_srl (.a_i(a_q), .b_i(b_q), .y_o(srl_y));
    sra_32 #(.WIDTH(WIDTH)) u_sra (.a_i(a_q), .b_i(b_q), .y_o(sra_y));

    always_comb begin
        case (op_q)
            OP_SLL:  shift_res = sll_y;
            OP_SRL:  shift_res = srl_y;
            OP_SRA:  shift_res = sra_y;
            default: shift_res = '0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            ST_IDLE: begin
                if (capture) begin
                    state_d = ST_EXEC;
                    owner_d = gnt_idx;
                end
            end
            ST_EXEC: begin
                state_d     = ST_HOLD;
                rsp_data_d  = shift_res;
                rsp_err_d   = op_is_ill(op_q);
                rsp_valid_d = NUM_REQ'(1) << owner_q;
            end
            ST_HOLD: begin
                if (accept) begin
                    rsp_valid_d = '0;
                    if (capture) begin
                        state_d = ST_EXEC;
                        owner_d = gnt_idx;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            owner_q     <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Operands are pure data: loaded on grant, only read in EXEC, so no reset needed.
    always_ff @(posedge clk) begin
        if (capture) begin
            op_q <= req_op[gnt_idx*2 +: 2];
            a_q  <= req_a[gnt_idx*WIDTH +: WIDTH];
            b_q  <= req_b[gnt_idx*WIDTH +: WIDTH];
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_shift_unit_arbiter.sv
// Directed bench for shift_unit_arbiter: vector table plus reset, round-robin and hold sequences.
module tb_shift_unit_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
    logic [3:0]  req_op;
    logic [63:0] req_a, req_b;
    logic [31:0] rsp_data;
    logic        rsp_err, busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    shift_unit_arbiter #(.NUM_REQ(2), .WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    typedef struct {
        int          idx;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int idx, input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] b);
        req_op[idx*2 +: 2]  = op;
        req_a[idx*32 +: 32] = a;
        req_b[idx*32 +: 32] = b;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0]  oh;
        logic [1:0]  exp_rv;
        logic [31:0] d0;

        vecs[0]  = '{0, 2'b00, 32'h0000_0001, 32'd4,          32'h0000_0010, 1'b0};
        vecs[1]  = '{1, 2'b10, 32'h8000_0000, 32'd31,         32'hFFFF_FFFF, 1'b0};
        vecs[2]  = '{1, 2'b10, 32'h8000_0000, 32'd40,         32'hFFFF_FFFF, 1'b0};
        vecs[3]  = '{1, 2'b01, 32'h8000_0000, 32'd32,         32'h0000_0000, 1'b0};
        vecs[4]  = '{0, 2'b01, 32'hF000_0000, 32'd4,          32'h0F00_0000, 1'b0};
        vecs[5]  = '{0, 2'b10, 32'h7000_0000, 32'd4,          32'h0700_0000, 1'b0};
        vecs[6]  = '{1, 2'b00, 32'h0000_FFFF, 32'd16,         32'hFFFF_0000, 1'b0};
        vecs[7]  = '{0, 2'b00, 32'h0000_0001, 32'h0000_0100,  32'h0000_0000, 1'b0};
        vecs[8]  = '{0, 2'b10, 32'h7000_0000, 32'h8000_0000,  32'h0000_0000, 1'b0};
        vecs[9]  = '{1, 2'b11, 32'h0000_1234, 32'd4,          32'h0000_0000, 1'b1};
        vecs[10] = '{1, 2'b00, 32'h0000_0003, 32'd1,          32'h0000_0006, 1'b0};
        vecs[11] = '{0, 2'b10, 32'h8000_0000, 32'd0,          32'h8000_0000, 1'b0};

        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = '0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data",  rsp_data,       32'd0);
        chk("rst_rsp_err",   32'(rsp_err),   32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        rst = 1'b0;
        tick();

        // Single-requester transactions from the vector table
        for (int i = 0; i < 12; i++) begin
            oh = 2'b01 << vecs[i].idx;
            set_req(vecs[i].idx, vecs[i].op, vecs[i].a, vecs[i].b);
            req_valid = oh;
            #1;
            chk($sformatf("v%0d_grant", i), 32'(req_ready), 32'(oh));
            tick();
            req_valid = '0;
            #1;
            chk($sformatf("v%0d_exec_rv", i),   32'(rsp_valid), 32'd0);
            chk($sformatf("v%0d_exec_busy", i), 32'(busy),      32'd1);
            tick();
            chk($sformatf("v%0d_rsp_valid", i), 32'(rsp_valid), 32'(oh));
            chk($sformatf("v%0d_data", i),      rsp_data,       vecs[i].exp_data);
            chk($sformatf("v%0d_err", i),       32'(rsp_err),   32'(vecs[i].exp_err));
            rsp_ready = oh;
            #1;
            chk($sformatf("v%0d_no_regrant", i), 32'(req_ready), 32'd0);
            tick();
            rsp_ready = '0;
            chk($sformatf("v%0d_done_rv", i),   32'(rsp_valid), 32'd0);
            chk($sformatf("v%0d_done_busy", i), 32'(busy),      32'd0);
        end

        // Reset pulse while an op is in EXEC
        set_req(0, 2'b00, 32'h0000_0001, 32'd4);
        req_valid = 2'b01;
        tick();
        req_valid = '0;
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_rsp_data",  rsp_data,       32'd0);
        chk("mid_rst_rsp_err",   32'(rsp_err),   32'd0);
        chk("mid_rst_busy",      32'(busy),      32'd0);
        chk("mid_rst_req_ready", 32'(req_ready), 32'd0);
        tick();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("post_rst_rv%0d", k),   32'(rsp_valid), 32'd0);
            chk($sformatf("post_rst_busy%0d", k), 32'(busy),      32'd0);
        end

        // Both requesters always valid: grants alternate, one op every two cycles
        set_req(0, 2'b00, 32'h0000_0001, 32'd1);
        set_req(1, 2'b00, 32'h0000_0001, 32'd2);
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        for (int k = 0; k < 7; k++) begin
            #1;
            if (k % 2 == 1) begin
                chk($sformatf("rr_k%0d_grant", k), 32'(req_ready), 32'd0);
                chk($sformatf("rr_k%0d_rv", k),    32'(rsp_valid), 32'd0);
            end else begin
                chk($sformatf("rr_k%0d_grant", k), 32'(req_ready),
                    ((k / 2) % 2 == 0) ? 32'd1 : 32'd2);
                if (k >= 2) begin
                    exp_rv = (((k / 2) - 1) % 2 == 0) ? 2'b01 : 2'b10;
                    chk($sformatf("rr_k%0d_rv", k),   32'(rsp_valid), 32'(exp_rv));
                    chk($sformatf("rr_k%0d_data", k), rsp_data,
                        (exp_rv == 2'b01) ? 32'd2 : 32'd4);
                end
            end
            tick();
        end
        req_valid = '0;
        tick();
        chk("rr_last_rv",    32'(rsp_valid), 32'd2);
        chk("rr_last_data",  rsp_data,       32'd4);
        chk("rr_last_grant", 32'(req_ready), 32'd0);
        tick();
        rsp_ready = '0;
        chk("rr_idle_busy", 32'(busy),      32'd0);
        chk("rr_idle_rv",   32'(rsp_valid), 32'd0);

        // Owner stalls the response; the other requester waits and its rsp_ready is ignored
        set_req(0, 2'b01, 32'h0000_0100, 32'd4);
        set_req(1, 2'b00, 32'h0000_0005, 32'd1);
        req_valid = 2'b01;
        #1;
        chk("hold_grant0", 32'(req_ready), 32'd1);
        tick();
        req_valid = 2'b11;
        rsp_ready = 2'b10;
        tick();
        d0 = 32'h0000_0010;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("hold_rv%0d", k),    32'(rsp_valid), 32'd1);
            chk($sformatf("hold_data%0d", k),  rsp_data,       d0);
            chk($sformatf("hold_grant%0d", k), 32'(req_ready), 32'd0);
            chk($sformatf("hold_busy%0d", k),  32'(busy),      32'd1);
            tick();
        end
        rsp_ready = 2'b01;
        #1;
        chk("hold_accept_grant1", 32'(req_ready), 32'd2);
        tick();
        req_valid = '0;
        rsp_ready = '0;
        tick();
        chk("hold_next_rv",   32'(rsp_valid), 32'd2);
        chk("hold_next_data", rsp_data,       32'h0000_000A);
        chk("hold_next_err",  32'(rsp_err),   32'd0);
        rsp_ready = 2'b10;
        tick();
        rsp_ready = '0;
        chk("hold_end_busy", 32'(busy),      32'd0);
        chk("hold_end_rv",   32'(rsp_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
